clk_period_monitor: RTL
=======================

// Module: clk_period_monitor
// PURPOSE
//  Receive-side checker for divided clocks from the clock divider (out_clk toggles every
//  DECIMATION clk cycles). Samples mon_clk in the clk domain, measures every half-period in
//  clk cycles, compares against EXPECTED +/- TOL, and reports lock, mismatches and stalls.
//  Sits beside each divider instance in the test designs as a self-check.
// PARAMETERS
//  EXPECTED   20'd16  nominal half-period of mon_clk, in clk cycles (= divider DECIMATION)
//  TOL        20'd0   allowed |measured - EXPECTED|, in clk cycles
//  LOCK_COUNT 4'd4    consecutive in-tolerance half-periods required to assert locked
//  TIMEOUT    20'hFFFFF  clk cycles without a mon_clk edge before a stall is declared
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  reset        in   1   synchronous, active-low reset
//  mon_clk      in   1   monitored divided clock (async-safe; treated as data)
//  enable       in   1   1 = monitor runs; 0 = hold in ACQUIRE, counters frozen at 0
//  half_period  out  20  last measured half-period (clk cycles)
//  meas_valid   out  1   1-cycle pulse when half_period updates
//  locked       out  1   1 while in LOCKED
//  err_pulse    out  1   1-cycle pulse on out-of-tolerance measurement or stall
//  stall        out  1   sticky: timeout seen since last reset/re-enable
//  err_count    out  16  saturating count of err_pulse events
// BEHAVIOUR
//  - reset==0 at posedge clk: all outputs 0, synchronizer 0, cnt 0, state ACQUIRE.
//  - mon_clk -> 2-FF synchronizer -> edge register; edge = sync ^ sync_d (both edges).
//    Edge flagged 3 clk cycles after mon_clk changes (fixed, identical for both edges).
//  - cnt (20b): cycles since last edge. Edge cycle: meas = cnt+1, cnt <= 0.
//    Otherwise cnt <= cnt+1, saturating at 20'hFFFFF (never wraps).
//  - Divider with DECIMATION=16: edges every 16 clk -> meas = 16 every edge.
//  - in_tol = (meas >= EXPECTED-TOL) && (meas <= EXPECTED+TOL); 21-bit arithmetic,
//    lower bound clamped at 0, upper bound clamped at 20'hFFFFF.
//  - FSM, 2 bits:
//    ACQUIRE: first edge only re-arms cnt (no meas_valid; partial period discarded) -> MEASURE.
//    MEASURE: each edge: meas_valid=1, half_period=meas. in_tol: good_cnt++; good_cnt reaches
//      LOCK_COUNT -> LOCKED. Not in_tol: good_cnt=0, err_pulse=1.
//    LOCKED: locked=1. Edge in_tol: stay. Edge not in_tol: err_pulse=1, good_cnt=0 -> MEASURE.
//    Any state except ACQUIRE: cnt == TIMEOUT-1 without edge -> err_pulse=1, stall=1,
//      good_cnt=0 -> ACQUIRE (one err per timeout, not repeated while idle).
//  - Edge and timeout in same cycle: edge wins (measurement taken, no stall).
//  - locked, meas_valid, err_pulse registered; change on the clk edge after the decision.
//  - err_count: +1 per err_pulse, saturates at 16'hFFFF.
//  - enable 0: state ACQUIRE, cnt/good_cnt 0, pulses 0; half_period, err_count held;
//    stall cleared on 0->1 of enable.
//  - Reset mid-measurement: all state discarded; next run re-acquires (first edge ignored).
// STRUCTURE
//  - Shared package (clk_div_pkg): state encoding localparams ST_ACQUIRE=0, ST_MEASURE=1,
//    ST_LOCKED=2; counter width CNT_W=20 (common with the divider).
//  - One sub-module: sync_edge_det (2-FF sync + both-edge pulse), reusable elsewhere.
//  - Top: counter, tolerance compare, FSM, error counter.
// TESTING
//  1 Divider DECIMATION=16 drives mon_clk, TOL=0: after 1+4 edges locked=1; every meas=16,
//    err_count stays 0.
//  2 Locked, one half-period stretched to 18 clk: meas_valid with half_period=18, err_pulse
//    1 cycle, locked drops next cycle, relocks after 4 good edges; err_count=1.
//  3 TOL=2, half-periods alternating 15/17: locks, no err_pulse.
//  4 TIMEOUT=100, stop mon_clk while locked: exactly 100 cycles after last edge err_pulse=1,
//    stall=1, locked=0; restart mon_clk -> first edge ignored, relock after 4 more.
//  5 Reset (low) for 1 cycle mid-half-period: all outputs 0 next cycle; first post-reset
//    edge gives no meas_valid.
//  6 Force 70000 errors: err_count saturates at 16'hFFFF; enable toggle clears stall only.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: state encoding and counter width shared by the clock divider and its monitor
package clk_div_pkg;
  localparam int CNT_W = 20;
  typedef enum logic [1:0] {ST_ACQUIRE = 2'd0, ST_MEASURE = 2'd1, ST_LOCKED = 2'd2} state_t;
endpackage

// File: rtl/clk_period_monitor_sync.sv
// sync_edge_det: 2-FF synchronizer plus delay register, pulses on both edges of i_d
module sync_edge_det (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_edge
);
  logic [2:0] r_sh;
  always_ff @(posedge i_clk) r_sh <= !i_reset_n ? 3'b000 : {r_sh[1:0], i_d};
  assign o_edge = r_sh[2] ^ r_sh[1];
endmodule

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures mon_clk half-periods, checks tolerance, reports lock/errors/stalls
module clk_period_monitor
  import clk_div_pkg::*;
#(
  parameter logic [CNT_W-1:0] EXPECTED   = 20'd16,
  parameter logic [CNT_W-1:0] TOL        = 20'd0,
  parameter logic [3:0]       LOCK_COUNT = 4'd4,
  parameter logic [CNT_W-1:0] TIMEOUT    = 20'hFFFFF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_mon_clk,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_half_period,
  output logic             o_meas_valid,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic             o_stall,
  output logic [15:0]      o_err_count
);
  localparam logic [CNT_W:0]   HI_RAW = {1'b0, EXPECTED} + {1'b0, TOL};
  localparam logic [CNT_W-1:0] LO     = (EXPECTED >= TOL) ? EXPECTED - TOL : '0;
  localparam logic [CNT_W-1:0] HI     = HI_RAW[CNT_W] ? '1 : HI_RAW[CNT_W-1:0];
  localparam logic [CNT_W-1:0] TO_M1  = TIMEOUT - 1'b1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_good;
  logic             r_en_d;
  logic             w_edge, w_acq, w_in_tol, w_bad, w_timeout, w_err;
  logic [CNT_W-1:0] w_meas;
  logic [3:0]       w_good_nx;
  sync_edge_det u_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_d      (i_mon_clk),
    .o_edge   (w_edge)
  );
  assign w_meas    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_in_tol  = (w_meas >= LO) && (w_meas <= HI);
  assign w_acq     = r_state == ST_ACQUIRE;
  assign w_bad     = w_edge && !w_acq && !w_in_tol;
  // an edge arriving on the timeout cycle is measured instead of declaring a stall
  assign w_timeout = !w_acq && !w_edge && (r_cnt == TO_M1);
  assign w_err     = i_enable && (w_bad || w_timeout);
  assign w_good_nx = r_good + 4'd1;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= ST_ACQUIRE;
      r_cnt         <= '0;
      r_good        <= '0;
      r_en_d        <= 1'b0;
      o_half_period <= '0;
      o_meas_valid  <= 1'b0;
      o_locked      <= 1'b0;
      o_err_pulse   <= 1'b0;
      o_stall       <= 1'b0;
    end else begin
      r_en_d       <= i_enable;
      o_meas_valid <= 1'b0;
      o_err_pulse  <= w_err;
      if (!i_enable) begin
        r_state  <= ST_ACQUIRE;
        r_cnt    <= '0;
        r_good   <= '0;
        o_locked <= 1'b0;
      end else begin
        if (!r_en_d) o_stall <= 1'b0;
        r_cnt <= w_edge ? '0 : w_meas;
        if (w_edge && w_acq) begin
          r_state <= ST_MEASURE;
        end else if (w_edge) begin
          o_meas_valid  <= 1'b1;
          o_half_period <= w_meas;
          if (!w_in_tol) begin
            r_good   <= '0;
            r_state  <= ST_MEASURE;
            o_locked <= 1'b0;
          end else if (r_state == ST_MEASURE) begin
            r_good   <= w_good_nx;
            r_state  <= (w_good_nx == LOCK_COUNT) ? ST_LOCKED : ST_MEASURE;
            o_locked <= w_good_nx == LOCK_COUNT;
          end
        end else if (w_timeout) begin
          r_good   <= '0;
          r_state  <= ST_ACQUIRE;
          o_locked <= 1'b0;
          o_stall  <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge i_clk) o_err_count <= !i_reset_n ? 16'd0 : (w_err && o_err_count != 16'hFFFF) ? o_err_count + 16'd1 : o_err_count;
endmodule
